instr_fetch_stage: RTL
======================

// Module: instr_fetch_stage
// PURPOSE
//  Fetch stage ahead of the opcode decoder. Holds the PC and issues one instruction-memory read at a time.
//  Presents the fetched word plus its PC as a one-entry IF/ID buffer with valid/ready.
//  if_opcode = if_instr[31:26] drives the control unit's six-bit opcode input directly.
//  Accepts taken-branch/jump redirects, discarding any fetch on the wrong path.
// PARAMETERS
//  ADDR_W    32            PC / memory address width
//  RESET_PC  32'h0000_0000 PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk             in   1       single clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  imem_req        out  1       read request; held until imem_gnt
//  imem_addr       out  ADDR_W  word-aligned read address, stable while imem_req=1
//  imem_gnt        in   1       request accepted this cycle
//  imem_rvalid     in   1       read data valid; >=1 cycle after gnt; one outstanding max
//  imem_rdata      in   32      instruction word
//  id_ready        in   1       decode consumes the IF/ID buffer this cycle
//  if_valid        out  1       IF/ID buffer holds a valid instruction
//  if_instr        out  32      buffered instruction
//  if_opcode       out  6       if_instr[31:26], to control unit
//  if_pc           out  ADDR_W  address of if_instr
//  if_pc4          out  ADDR_W  if_pc + 4, mod 2^ADDR_W
//  redirect_valid  in   1       taken branch/jump this cycle
//  redirect_pc     in   ADDR_W  target; bits [1:0] forced to 0 internally
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=S_REQ, drop=0; imem_req=0, imem_addr=RESET_PC,
//   if_valid=0, if_instr=0, if_pc=RESET_PC, if_pc4=RESET_PC+4. First imem_req in the first cycle after release.
//  States:
//   S_REQ:  imem_req=1, imem_addr=pc. On gnt -> S_WAIT.
//   S_WAIT: await imem_rvalid. On rvalid with drop=0: load buffer (instr, pc), pc<=pc+4, if_valid<=1.
//           Next state: S_REQ if buffer free or consumed same cycle (id_ready), else S_HOLD.
//           On rvalid with drop=1: discard data, clear drop, -> S_REQ.
//   S_HOLD: buffer full, no request issued. When id_ready -> S_REQ.
//  Consume: if_valid & id_ready clears if_valid, unless a new word loads the same cycle (load wins).
//  Redirect (priority over everything, incl. stall and a same-cycle rvalid):
//   pc<=redirect_pc&~3, if_valid<=0.
//   In S_WAIT, or in S_REQ with gnt this cycle: set drop=1, go/stay S_WAIT; response later discarded.
//   Otherwise -> S_REQ at redirect_pc next cycle.
//   A redirect while drop=1 just updates pc.
//  imem_req never drops without gnt unless a redirect occurs; the new address appears next cycle.
//  PC arithmetic modulo 2^ADDR_W: 0xFFFF_FFFC + 4 = 0x0000_0000, no flag.
//  Throughput: one instruction per 2 cycles with 1-cycle gnt->rvalid latency (no prefetch).
//  if_* outputs change only on load, consume or redirect; stable while if_valid & ~id_ready.
//  Reset mid-fetch: all state cleared at once. A late rvalid after release is ignored unless in S_WAIT.
// TESTING
//  1 Release rst_n, gnt tied 1, rvalid 1 cycle later, id_ready=1 -> addrs 0x0,0x4,0x8;
//    if_pc/if_pc4 = 0x0/0x4 then 0x4/0x8.
//  2 rdata=0x8C01_0004 loaded -> if_opcode=6'd35; id_ready=0 for 5 cycles -> no imem_req,
//    if_* stable; id_ready=1 -> next req at 0x4.
//  3 redirect_valid, redirect_pc=0x100 while in S_WAIT at 0x8 -> 0x8 data dropped, if_valid stays 0;
//    next req at 0x100, if_pc=0x100.
//  4 redirect_pc=0x203 in S_HOLD -> if_valid=0 next cycle; req at 0x200.
//  5 RESET_PC=0xFFFF_FFFC -> first if_pc4=0x0; next req at 0x0.
//  6 Assert rst_n=0 mid-S_WAIT, stray rvalid during reset -> outputs at reset values;
//    first post-reset req at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: one outstanding imem read feeding a one-entry IF/ID buffer.
// Redirects retarget the PC and discard any in-flight wrong-path response.
//
// state  | meaning
// S_REQ  | imem_req asserted at pc, waiting for gnt
// S_WAIT | request accepted, waiting for rvalid (response discarded when drop_q)
// S_HOLD | buffer full and decode stalled, no request issued
module instr_fetch_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [5:0]        if_opcode,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ifpc_q, ifpc_d;
    logic [ADDR_W-1:0] redirect_pc_al;

    assign redirect_pc_al = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;

        if (valid_q && id_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        valid_d = 1'b1;
                        instr_d = imem_rdata;
                        ifpc_d  = pc_q;
                        pc_d    = pc_q + PC_STEP;
                        // id_ready at load time decides whether the next fetch may start now
                        state_d = id_ready ? S_REQ : S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A response arriving in the same cycle is simply discarded; only a still-pending one sets drop.
        if (redirect_valid) begin
            pc_d    = redirect_pc_al;
            valid_d = 1'b0;
            instr_d = instr_q;
            ifpc_d  = ifpc_q;
            if ((state_q == S_WAIT && !imem_rvalid) || (state_q == S_REQ && imem_gnt)) begin
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = S_REQ;
            end
        end
    end

    assign imem_req  = rst_n && (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_opcode = instr_q[31:26];
    assign if_pc     = ifpc_q;
    assign if_pc4    = ifpc_q + PC_STEP;

endmodule
